// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
//
// Purpose: bundles every bus-level signal around ram_arbiter. This covers
// both requester ports (instruction controller on port 0, loader/DMA on
// port 1), the shared single-port data RAM strobes, and the two status
// flags. Clock and reset are not part of the bundle.
//
// Parameters:
//   AW - RAM address width
//   DW - RAM data width
//
// Signal summary (direction as seen by the arbiter):
//   m0_req/m1_req       in   request, held until the matching done
//   m0_we/m1_we         in   1 = write, 0 = read
//   m0_addr/m1_addr     in   target address
//   m0_wdata/m1_wdata   in   write data
//   m0_gnt/m1_gnt       out  ownership, SETUP through DONE
//   m0_done/m1_done     out  one-cycle completion pulse
//   m0_rdata/m1_rdata   out  read data, held until that port's next read
//   ram_cs/re/we        out  RAM chip select and strobes
//   ram_addr            out  RAM address
//   ram_data_out        out  write data to RAM
//   ram_data_in         in   registered read data from RAM
//   busy                out  arbiter is not idle
//   conflict            out  both ports requested in the same idle cycle
//
// Modports:
//   slave  - the arbiter's view. It serves the requesters and the RAM
//            environment.
//   master - the view of the environment, meaning the requesters plus the RAM.
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_done;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_done;
    logic [DW-1:0] m1_rdata;

    logic          ram_cs;
    logic          ram_re;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_out;
    logic [DW-1:0] ram_data_in;

    logic          busy;
    logic          conflict;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output ram_cs, ram_re, ram_we, ram_addr, ram_data_out,
        input  ram_data_in,
        output busy, conflict
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  ram_cs, ram_re, ram_we, ram_addr, ram_data_out,
        output ram_data_in,
        input  busy, conflict
    );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Purpose: shares the single data RAM between the instruction controller
// (port 0) and the loader/DMA engine (port 1). The arbiter accepts one
// transaction at a time. Each transaction steps the RAM strobes through a
// fixed four-cycle access: SETUP, ACCESS, WAIT, then DONE. A one-cycle done
// pulse returns read data to the winning port, and the RAM is then released.
// The arbiter always returns to IDLE for one cycle between transactions.
//
// Ports:
//   clk  - system clock. All state changes on the rising edge.
//   rst  - asynchronous, active-low reset.
//   bus  - ram_arbiter_if.slave. Carries the requester ports, the RAM
//          strobes, busy and conflict.
//
// Configuration:
//   RAM_ARB_RR_EN - when defined, simultaneous requests are resolved by
//                   round-robin: the port that was not served last wins.
//                   When undefined, port 0 always wins ties and no pointer
//                   is built.
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic          owner;
    logic          op_we;

    logic          any_req;
    logic          pick1;
    logic          pick_we;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

`ifdef RAM_ARB_RR_EN
    // Records which port was granted most recently. After reset it reads as
    // port 1, so the first tie goes to port 0.
    logic          last_served;
`endif

    // Choose the winner while idle and mux its request fields. The result
    // matters only in IDLE, because requester inputs are ignored once a
    // transaction is under way.
    always_comb begin
        any_req    = bus.m0_req | bus.m1_req;
        pick1      = 1'b0;
`ifdef RAM_ARB_RR_EN
        if (bus.m0_req && bus.m1_req) begin
            pick1 = ~last_served;
        end else begin
            pick1 = bus.m1_req;
        end
`else
        pick1 = bus.m1_req & ~bus.m0_req;
`endif
        pick_we    = pick1 ? bus.m1_we    : bus.m0_we;
        pick_addr  = pick1 ? bus.m1_addr  : bus.m0_addr;
        pick_wdata = pick1 ? bus.m1_wdata : bus.m0_wdata;
    end

    // conflict must be visible during the idle cycle that does the
    // arbitrating, so it is decoded from the current state rather than
    // registered. It is masked during reset so that every output reads 0
    // while rst is low.
    assign bus.conflict = rst && (state == IDLE) && bus.m0_req && bus.m1_req;

    // Main sequencer. Every other output is registered here. The RAM address
    // and write data are loaded once at grant and then held, which keeps the
    // access stable even if the requester changes its inputs mid-flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            owner            <= 1'b0;
            op_we            <= 1'b0;
            bus.m0_gnt       <= 1'b0;
            bus.m1_gnt       <= 1'b0;
            bus.m0_done      <= 1'b0;
            bus.m1_done      <= 1'b0;
            bus.m0_rdata     <= '0;
            bus.m1_rdata     <= '0;
            bus.ram_cs       <= 1'b0;
            bus.ram_re       <= 1'b0;
            bus.ram_we       <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_data_out <= '0;
            bus.busy         <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_served      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state            <= SETUP;
                        owner            <= pick1;
                        op_we            <= pick_we;
                        bus.ram_cs       <= 1'b1;
                        bus.ram_addr     <= pick_addr;
                        bus.ram_data_out <= pick_we ? pick_wdata : '0;
                        bus.m0_gnt       <= ~pick1;
                        bus.m1_gnt       <= pick1;
                        bus.busy         <= 1'b1;
`ifdef RAM_ARB_RR_EN
                        last_served      <= pick1;
`endif
                    end
                end
                SETUP: begin
                    state      <= ACCESS;
                    bus.ram_re <= ~op_we;
                    bus.ram_we <= op_we;
                end
                ACCESS: begin
                    state      <= WAIT;
                    bus.ram_re <= 1'b0;
                    bus.ram_we <= 1'b0;
                end
                WAIT: begin
                    // The RAM registered its output on the edge after the
                    // read strobe, so ram_data_in is valid to capture here.
                    state <= DONE;
                    if (!op_we) begin
                        if (owner) begin
                            bus.m1_rdata <= bus.ram_data_in;
                        end else begin
                            bus.m0_rdata <= bus.ram_data_in;
                        end
                    end
                    bus.m0_done <= ~owner;
                    bus.m1_done <= owner;
                end
                DONE: begin
                    state       <= IDLE;
                    bus.m0_done <= 1'b0;
                    bus.m1_done <= 1'b0;
                    bus.m0_gnt  <= 1'b0;
                    bus.m1_gnt  <= 1'b0;
                    bus.ram_cs  <= 1'b0;
                    bus.busy    <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.m0_done <= 1'b0;
                    bus.m1_done <= 1'b0;
                    bus.m0_gnt  <= 1'b0;
                    bus.m1_gnt  <= 1'b0;
                    bus.ram_cs  <= 1'b0;
                    bus.ram_re  <= 1'b0;
                    bus.ram_we  <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Purpose: directed test of ram_arbiter. A small behavioural RAM returns
// registered read data one edge after ram_re. Addresses that have never been
// written return fixed preset contents: 0x80 holds 0x1234, and any other
// address a holds {0x5A, a}.
//
// Define RAM_ARB_RR_EN for both this file and the design to expect
// round-robin grants in the tie sequence.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic exp_owner [4];

    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Contents of addresses that have never been written.
    function automatic logic [15:0] preset(input logic [7:0] a);
        return (a == 8'h80) ? 16'h1234 : {8'h5A, a};
    endfunction

    // Behavioural RAM: writes on the strobe edge, and read data is
    // registered one edge after ram_re.
    logic [15:0] mem [int];
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) begin
            mem[int'(bus.ram_addr)] = bus.ram_data_out;
        end
        if (bus.ram_cs && bus.ram_re) begin
            bus.ram_data_in <= mem.exists(int'(bus.ram_addr)) ?
                               mem[int'(bus.ram_addr)] : preset(bus.ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef RAM_ARB_RR_EN
        exp_owner[0] = 1'b0; exp_owner[1] = 1'b1;
        exp_owner[2] = 1'b0; exp_owner[3] = 1'b1;
`else
        exp_owner[0] = 1'b0; exp_owner[1] = 1'b0;
        exp_owner[2] = 1'b0; exp_owner[3] = 1'b0;
`endif
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_m0_gnt",   bus.m0_gnt,       0);
        check("rst_m1_gnt",   bus.m1_gnt,       0);
        check("rst_done",     {bus.m0_done, bus.m1_done}, 0);
        check("rst_cs_re_we", {bus.ram_cs, bus.ram_re, bus.ram_we}, 0);
        check("rst_busy",     bus.busy,         0);
        check("rst_conflict", bus.conflict,     0);
        check("rst_addr",     bus.ram_addr,     0);
        check("rst_dout",     bus.ram_data_out, 0);
        check("rst_rdata",    {bus.m0_rdata, bus.m1_rdata}, 0);
        rst = 1'b1;
        tick();

        // ---------------- port 0 write 0x12 <- 0xBEEF ----------------
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 8'h12; bus.m0_wdata = 16'hBEEF;
        #1;
        check("w_idle_conflict", bus.conflict, 0);
        tick(); // E0
        check("w_e0_gnt",  {bus.m0_gnt, bus.m1_gnt}, 2'b10);
        check("w_e0_cs",   bus.ram_cs,       1);
        check("w_e0_addr", bus.ram_addr,     8'h12);
        check("w_e0_dout", bus.ram_data_out, 16'hBEEF);
        check("w_e0_busy", bus.busy,         1);
        check("w_e0_we",   bus.ram_we,       0);
        tick(); // E1
        check("w_e1_strobes", {bus.ram_re, bus.ram_we}, 2'b01);
        check("w_e1_addr",    bus.ram_addr, 8'h12);
        tick(); // E2
        check("w_e2_strobes", {bus.ram_re, bus.ram_we}, 2'b00);
        tick(); // E3
        check("w_e3_done", {bus.m0_done, bus.m1_done}, 2'b10);
        bus.m0_req = 1'b0;
        tick(); // E4
        check("w_e4_done",  bus.m0_done,  0);
        check("w_e4_gnt",   bus.m0_gnt,   0);
        check("w_e4_cs",    bus.ram_cs,   0);
        check("w_e4_busy",  bus.busy,     0);
        check("w_e4_addr",  bus.ram_addr, 8'h12);
        check("w_e4_dout",  bus.ram_data_out, 16'hBEEF);

        // ---------------- port 0 read back 0x12 ----------------
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h12;
        tick(); // E0
        check("r0_e0_dout", bus.ram_data_out, 0);
        tick(); // E1
        check("r0_e1_strobes", {bus.ram_re, bus.ram_we}, 2'b10);
        tick(); // E2
        check("r0_e2_strobes", {bus.ram_re, bus.ram_we}, 2'b00);
        tick(); // E3
        check("r0_e3_done",  bus.m0_done,  1);
        check("r0_e3_rdata", bus.m0_rdata, 16'hBEEF);
        bus.m0_req = 1'b0;
        tick(); // E4
        check("r0_e4_done",  bus.m0_done,  0);
        check("r0_e4_rdata", bus.m0_rdata, 16'hBEEF);

        // ---------------- port 1 read 0x80 ----------------
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h80;
        tick(); // E0
        check("r1_e0_gnt",  {bus.m0_gnt, bus.m1_gnt}, 2'b01);
        check("r1_e0_addr", bus.ram_addr, 8'h80);
        tick(); // E1
        check("r1_e1_strobes", {bus.ram_re, bus.ram_we}, 2'b10);
        check("r1_e1_gnt",     bus.m1_gnt, 1);
        tick(); // E2
        check("r1_e2_re", bus.ram_re, 0);
        tick(); // E3
        check("r1_e3_done",  {bus.m0_done, bus.m1_done}, 2'b01);
        check("r1_e3_rdata", bus.m1_rdata, 16'h1234);
        check("r1_e3_m0gnt", bus.m0_gnt, 0);
        bus.m1_req = 1'b0;
        tick(); // E4
        check("r1_e4_gnt_done", {bus.m1_gnt, bus.m1_done}, 2'b00);

        // ---------------- both requesting, four transactions ----------------
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h20;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h21;
        #1;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("tie%0d_conflict", t), bus.conflict, 1);
            tick(); // E0
            check($sformatf("tie%0d_gnt", t), {bus.m0_gnt, bus.m1_gnt},
                  exp_owner[t] ? 2'b01 : 2'b10);
            check($sformatf("tie%0d_setup_conflict", t), bus.conflict, 0);
            tick(); tick(); tick(); // E3
            check($sformatf("tie%0d_done", t), {bus.m0_done, bus.m1_done},
                  exp_owner[t] ? 2'b01 : 2'b10);
            check($sformatf("tie%0d_rdata", t),
                  exp_owner[t] ? bus.m1_rdata : bus.m0_rdata,
                  exp_owner[t] ? 16'h5A21 : 16'h5A20);
            tick(); // E4
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick();

        // ---------------- address change mid-transaction ----------------
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h05;
        tick(); // E0
        check("chg_e0_addr", bus.ram_addr, 8'h05);
        tick(); // E1, now in ACCESS
        bus.m0_addr = 8'h06;
        tick(); // E2
        check("chg_e2_addr", bus.ram_addr, 8'h05);
        tick(); // E3
        check("chg_e3_addr",  bus.ram_addr, 8'h05);
        check("chg_e3_rdata", bus.m0_rdata, 16'h5A05);
        bus.m0_req = 1'b0;
        tick(); // E4
        check("chg_e4_addr", bus.ram_addr, 8'h05);

        // ---------------- reset during ACCESS of a write ----------------
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 8'h30; bus.m0_wdata = 16'h1111;
        tick(); // E0
        tick(); // E1
        check("rw_e1_we", bus.ram_we, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rw_rst_we",   bus.ram_we, 0);
        check("rw_rst_cs",   bus.ram_cs, 0);
        check("rw_rst_gnt",  {bus.m0_gnt, bus.m1_gnt}, 0);
        check("rw_rst_done", {bus.m0_done, bus.m1_done}, 0);
        check("rw_rst_busy", bus.busy, 0);
        check("rw_rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
        bus.m0_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h80;
        tick(); // E0
        check("post_e0_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b01);
        tick(); // E1
        check("post_e1_re", bus.ram_re, 1);
        tick(); // E2
        tick(); // E3
        check("post_e3_done",  bus.m1_done,  1);
        check("post_e3_rdata", bus.m1_rdata, 16'h1234);
        bus.m1_req = 1'b0;
        tick(); // E4
        check("post_e4_busy", {bus.busy, bus.m1_done, bus.m1_gnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single data RAM (cs/re/we/addr/data interface) between the instruction controller (port 0) and a port-side loader/DMA engine (port 1). It accepts one transaction at a time, sequences the RAM strobes through a fixed four-cycle access, returns read data with a one-cycle done pulse, and releases the RAM. It sits between both requesters and the RAM, replacing direct controller-to-RAM wiring.

## Interface
- AW, 8, RAM address width
- DW, 16, RAM data width

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; asynchronous and active-low
- m0_req / m1_req  in  1  request; held high until the matching done is sampled
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  AW  target address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  high from SETUP through DONE for the owning port
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DW  read data, valid while done high, held until next read by that port
- ram_cs  out  1  RAM chip select
- ram_re  out  1  RAM read strobe
- ram_we  out  1  RAM write strobe
- ram_addr  out  AW  RAM address
- ram_data_out  out  DW  write data to RAM
- ram_data_in  in  DW  read data from RAM (registered by RAM one edge after ram_re)
- busy  out  1  high in any state other than IDLE
- conflict  out  1  one-cycle pulse when both req are high in IDLE

## Operation
- States: IDLE, SETUP, ACCESS, WAIT, DONE; unused encodings -> IDLE.
- IDLE: if any req high, select a winner, latch its we/addr/wdata, drive ram_cs=1, ram_addr, ram_data_out (write data only; 0 on read), raise its gnt, go to SETUP.
- SETUP -> ACCESS: ram_re=1 (read) or ram_we=1 (write) for exactly one cycle.
- ACCESS -> WAIT: strobes return to 0.
- WAIT -> DONE: on read, capture ram_data_in into winner's rdata; winner's done=1.
- DONE -> IDLE: done=0, gnt=0, ram_cs=0, ram_addr and ram_data_out hold last value.
- Requester inputs are ignored outside IDLE; a req change mid-transaction has no effect.
- Requester drops req on the edge it samples done; a req still high in IDLE is a new transaction.
- Arbitration (default): fixed priority, port 0 wins ties.
- Only one gnt high at any time; ram_re and ram_we never both high.
- Reset (any state): state IDLE, all outputs 0, rdata registers 0, in-flight transaction abandoned with no done; RR pointer to "last served = port 1".

## Timing
- Req high before edge E0 in IDLE: E0 gnt/cs/addr valid; E1 strobe high; E2 strobe low; E3 done high; E4 done/gnt/cs low.
- Request-to-done latency 4 cycles; RAM occupied 4 cycles; one mandatory IDLE cycle between transactions, so back-to-back throughput is one access per 5 cycles.
- Read data sampled at E3 (two edges after strobe rise).
- conflict asserted for the single IDLE cycle that arbitrates both.

## Configuration
- RAM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not served last wins; a single requester always wins; pointer updates at grant.
- Undefined: fixed priority, port 0 always wins ties; pointer logic absent.

## Test plan
- Port 0 write addr 0x12 data 0xBEEF, then read 0x12 -> ram_we high one cycle at E1 with addr 0x12, read returns m0_rdata=0xBEEF with m0_done at E3.
- Port 1 read addr 0x80 with RAM returning 0x1234 -> m1_gnt E0–E3, ram_re only at E1, m1_done and m1_rdata=0x1234 at E3, m0 outputs stay 0.
- Both req held high for 4 transactions, macro undefined -> all four granted to port 0, conflict pulses each arbitration; with RAM_ARB_RR_EN -> grants alternate 0,1,0,1.
- Port 0 changes addr 0x05 -> 0x06 during ACCESS -> ram_addr stays 0x05 through DONE.
- rst low during ACCESS of a write -> ram_we, ram_cs, gnt, done, busy all 0 immediately; after release a new port 1 request completes normally in 4 cycles.
